pkt_reorder_vlen: RTL

PKT_REORDER_VLEN -- requirements
Module: pkt_reorder_vlen

---
 rtl/pkt_reorder_vlen.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/pkt_reorder_vlen.sv
// Packet reorder buffer for variable-length packets.
// Beats of up to PKT_NUM interleaved packets are stored per ID; complete
// packets are replayed contiguously in the order their SOP beats arrived.
module pkt_reorder_vlen #(
  parameter int PKT_NUM    = 16,
  parameter int MAX_BEATS  = 8,
  parameter int DATA_WIDTH = 8,
  localparam int ID_W      = $clog2(PKT_NUM),
  localparam int CNT_W     = $clog2(PKT_NUM + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld_in,
  input  logic [ID_W-1:0]       pkt_id_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  SOP_in,
  input  logic                  EOP_in,
  output logic                  vld_out,
  input  logic                  rdy_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  SOP_out,
  output logic                  EOP_out,
  output logic [ID_W-1:0]       pkt_id_out,
  output logic                  err_out,
  output logic [1:0]            err_code,
  output logic [CNT_W-1:0]      open_cnt
);

  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  localparam int DEPTH  = PKT_NUM * MAX_BEATS;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_reg, state_next;
  logic [PKT_NUM-1:0]    open_vec, cmpl_vec;
  logic [BEAT_W-1:0]     cnt_arr [PKT_NUM];
  logic [ID_W-1:0]       fifo_mem [PKT_NUM];
  logic [ID_W-1:0]       wr_ptr_reg, rd_ptr_reg, head_id;
  logic [CNT_W-1:0]      open_cnt_reg;
  logic [DATA_WIDTH-1:0] beat_mem [DEPTH];
  logic [ADDR_W-1:0]     wr_addr, rd_addr;
  logic                  wr_en;
  logic [BEAT_W-1:0]     in_cnt, head_cnt, beat_idx_reg;
  logic                  sop_ok, cont_ok, err_now;
  logic [1:0]            code_now;
  logic                  load_first, advance, pop;
  logic                  vld_reg, sop_reg, eop_reg, err_reg;
  logic [1:0]            err_code_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [ID_W-1:0]       id_out_reg;

  assign head_id  = fifo_mem[rd_ptr_reg];
  assign head_cnt = cnt_arr[head_id];
  assign in_cnt   = cnt_arr[pkt_id_in];

  // Classify the incoming beat: accepted SOP, accepted continuation, or error
  always_comb begin
    sop_ok   = 1'b0;
    cont_ok  = 1'b0;
    err_now  = 1'b0;
    code_now = 2'b00;
    if (vld_in) begin
      if (SOP_in) begin
        if (open_vec[pkt_id_in]) begin
          err_now  = 1'b1;
          code_now = 2'b01;
        end else begin
          sop_ok = 1'b1;
        end
      end else if (!open_vec[pkt_id_in] || cmpl_vec[pkt_id_in]) begin
        err_now  = 1'b1;
        code_now = 2'b10;
      end else if (in_cnt == BEAT_W'(MAX_BEATS)) begin
        err_now  = 1'b1;
        code_now = 2'b11;
      end else begin
        cont_ok = 1'b1;
      end
    end
  end

  assign wr_en   = (sop_ok || cont_ok) && !rst;
  assign wr_addr = ADDR_W'(pkt_id_in) * ADDR_W'(MAX_BEATS)
                 + (SOP_in ? '0 : ADDR_W'(in_cnt));
  assign rd_addr = ADDR_W'(head_id) * ADDR_W'(MAX_BEATS)
                 + (load_first ? '0 : ADDR_W'(beat_idx_reg + BEAT_W'(1)));

  // Per-ID bookkeeping: open/complete flags and stored beat count
  generate
    for (genvar gi = 0; gi < PKT_NUM; gi++) begin : g_id
      logic              open_q, cmpl_q;
      logic [BEAT_W-1:0] cnt_q;
      logic              hit_in, hit_pop;

      assign hit_in  = (pkt_id_in == ID_W'(gi));
      assign hit_pop = pop && (head_id == ID_W'(gi));

      // Open on SOP, count beats, mark complete on EOP, release on pop
      always_ff @(posedge clk) begin
        if (rst) begin
          open_q <= 1'b0;
          cmpl_q <= 1'b0;
          cnt_q  <= '0;
        end else if (sop_ok && hit_in) begin
          open_q <= 1'b1;
          cmpl_q <= EOP_in;
          cnt_q  <= BEAT_W'(1);
        end else if (cont_ok && hit_in) begin
          cnt_q <= cnt_q + BEAT_W'(1);
          if (EOP_in) cmpl_q <= 1'b1;
        end else if (hit_pop) begin
          open_q <= 1'b0;
          cmpl_q <= 1'b0;
        end
      end

      assign open_vec[gi] = open_q;
      assign cmpl_vec[gi] = cmpl_q;
      assign cnt_arr[gi]  = cnt_q;
    end
  endgenerate

  // SOP-order FIFO of IDs; its occupancy doubles as the open packet count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      open_cnt_reg <= '0;
    end else begin
      if (sop_ok) begin
        fifo_mem[wr_ptr_reg] <= pkt_id_in;
        wr_ptr_reg           <= wr_ptr_reg + ID_W'(1);
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + ID_W'(1);
      if (sop_ok && !pop)      open_cnt_reg <= open_cnt_reg + CNT_W'(1);
      else if (!sop_ok && pop) open_cnt_reg <= open_cnt_reg - CNT_W'(1);
    end
  end

  // Beat storage write port (contents are not cleared by reset)
  always_ff @(posedge clk) begin
    if (wr_en) beat_mem[wr_addr] <= data_in;
  end

  // Error pulse, one cycle after the offending beat
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg      <= 1'b0;
      err_code_reg <= 2'b00;
    end else begin
      err_reg      <= err_now;
      err_code_reg <= code_now;
    end
  end

  // Output FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Output FSM next state: start when the oldest packet is complete
  always_comb begin
    state_next = state_reg;
    load_first = 1'b0;
    advance    = 1'b0;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (open_cnt_reg != '0 && cmpl_vec[head_id]) begin
          load_first = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (vld_reg && rdy_out) begin
          if (eop_reg) begin
            pop        = 1'b1;
            state_next = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered read of the presented beat; zero while nothing is presented
  always_ff @(posedge clk) begin
    if (rst)                        data_reg <= '0;
    else if (load_first || advance) data_reg <= beat_mem[rd_addr];
    else if (pop)                   data_reg <= '0;
  end

  // Output beat framing: valid, SOP/EOP markers, ID and beat index
  always_ff @(posedge clk) begin
    if (rst || pop) begin
      vld_reg      <= 1'b0;
      sop_reg      <= 1'b0;
      eop_reg      <= 1'b0;
      id_out_reg   <= '0;
      beat_idx_reg <= '0;
    end else if (load_first) begin
      vld_reg      <= 1'b1;
      sop_reg      <= 1'b1;
      eop_reg      <= (head_cnt == BEAT_W'(1));
      id_out_reg   <= head_id;
      beat_idx_reg <= '0;
    end else if (advance) begin
      sop_reg      <= 1'b0;
      eop_reg      <= (beat_idx_reg + BEAT_W'(2) == head_cnt);
      beat_idx_reg <= beat_idx_reg + BEAT_W'(1);
    end
  end

  assign vld_out    = vld_reg;
  assign data_out   = data_reg;
  assign SOP_out    = sop_reg;
  assign EOP_out    = eop_reg;
  assign pkt_id_out = id_out_reg;
  assign err_out    = err_reg;
  assign err_code   = err_code_reg;
  assign open_cnt   = open_cnt_reg;

endmodule
